// File: rtl/issue_pkg.sv
// Shared constants for the issue-select slice: default buffer depth, index
// width derivation and the two-state FSM encoding.
package issue_pkg;

  localparam int BS = 16;

  function automatic int index_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int BS_IW = index_width(BS);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

endpackage

// File: rtl/age_priority_picker.sv
// Circular find-first-set: returns the first set bit of mask at or after
// head, wrapping from bs-1 to 0.
module age_priority_picker
  import issue_pkg::*;
#(
  parameter int bs = BS,
  localparam int IW = index_width(bs)
) (
  input  logic [bs-1:0] mask,
  input  logic [IW-1:0] head,
  output logic          found,
  output logic [IW-1:0] index
);

  logic [bs-1:0] rot;
  logic [IW-1:0] off;

  // Rotate so the head entry lands at bit 0; IW-bit addition wraps modulo bs.
  always_comb begin
    rot = '0;
    for (int i = 0; i < bs; i++) begin
      rot[i] = mask[IW'(i) + head];
    end
  end

  // Scan downward so the lowest set bit of rot is the one left standing.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = IW'(i);
      end
    end
  end

  assign index = off + head;

endmodule

// File: rtl/issue_select.sv
// Picks the oldest dependency-free, not-yet-issued buffer entry, offers it on
// a valid/ready handshake, tracks issued entries and broadcasts wakeups.
module issue_select
  import issue_pkg::*;
#(
  parameter int bs = BS,
  localparam int IW = index_width(bs)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [bs-1:0] ready_positions,
  input  logic [IW-1:0] head_index,
  input  logic          alloc_valid,
  input  logic [IW-1:0] alloc_index,
  input  logic          flush,
  input  logic          issue_ready,
  output logic          issue_valid,
  output logic [IW-1:0] issue_index,
  output logic          wakeup_valid,
  output logic [IW-1:0] wakeup_index,
  output logic [bs-1:0] issued_mask
);

  localparam logic [bs-1:0] ONE = {{(bs-1){1'b0}}, 1'b1};

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [bs-1:0] issued_q, issued_d;
  logic          wv_q, wv_d;
  logic [IW-1:0] wi_q, wi_d;

  logic          fire, found;
  logic [IW-1:0] pick;
  logic [bs-1:0] offer_oh, alloc_oh, cand;

  assign issue_valid  = (state_q == ST_OFFER);
  assign issue_index  = idx_q;
  assign wakeup_valid = wv_q;
  assign wakeup_index = wi_q;
  assign issued_mask  = issued_q;

  assign fire     = issue_valid & issue_ready;
  assign offer_oh = issue_valid ? (ONE << idx_q) : '0;
  assign alloc_oh = alloc_valid ? (ONE << alloc_index) : '0;
  // The held entry and the entry being rewritten are never candidates.
  assign cand     = ready_positions & ~issued_q & ~offer_oh & ~alloc_oh;

  age_priority_picker #(.bs(bs)) u_picker (
    .mask  (cand),
    .head  (head_index),
    .found (found),
    .index (pick)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    issued_d = issued_q;
    wv_d     = fire;
    wi_d     = wi_q;

    if (state_q == ST_IDLE) begin
      if (found) begin
        state_d = ST_OFFER;
        idx_d   = pick;
      end
    end else if (fire) begin
      if (found) idx_d = pick;
      else       state_d = ST_IDLE;
    end

    if (fire) begin
      wi_d            = idx_q;
      issued_d[idx_q] = 1'b1;
    end
    // Applied after the fire so a same-index reallocation leaves the bit clear.
    if (alloc_valid) issued_d[alloc_index] = 1'b0;

    if (flush) begin
      state_d  = ST_IDLE;
      issued_d = '0;
      wv_d     = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the issued vector is ordinary flops and is reset too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      issued_q <= '0;
      wv_q     <= 1'b0;
      wi_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      issued_q <= issued_d;
      wv_q     <= wv_d;
      wi_q     <= wi_d;
    end
  end

endmodule

// File: tb/tb_issue_select.sv
// Self-checking bench for issue_select: directed scenarios plus a randomized
// run compared against a behavioural model of the selection rules.
module tb_issue_select;
  import issue_pkg::*;

  localparam int N  = BS;
  localparam int NW = BS_IW;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  ready_positions;
  logic [NW-1:0] head_index;
  logic          alloc_valid;
  logic [NW-1:0] alloc_index;
  logic          flush;
  logic          issue_ready;
  logic          issue_valid;
  logic [NW-1:0] issue_index;
  logic          wakeup_valid;
  logic [NW-1:0] wakeup_index;
  logic [N-1:0]  issued_mask;

  always #5 clk = ~clk;

  issue_select dut (
    .clk             (clk),
    .rst             (rst),
    .ready_positions (ready_positions),
    .head_index      (head_index),
    .alloc_valid     (alloc_valid),
    .alloc_index     (alloc_index),
    .flush           (flush),
    .issue_ready     (issue_ready),
    .issue_valid     (issue_valid),
    .issue_index     (issue_index),
    .wakeup_valid    (wakeup_valid),
    .wakeup_index    (wakeup_index),
    .issued_mask     (issued_mask)
  );

  // Upstream must never reallocate the entry held in OFFER unless it fires.
  always @(posedge clk) begin
    if (!rst && alloc_valid && issue_valid && !issue_ready)
      assert (alloc_index != issue_index)
        else $error("illegal alloc of held entry %0d", alloc_index);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: explicit per-entry flags and an age-ordered scan.
  bit m_valid;
  int m_idx;
  bit m_issued [N];
  bit m_wv;
  int m_wi;
  bit fired_since [N];

  function automatic logic [N-1:0] model_mask();
    logic [N-1:0] m;
    for (int e = 0; e < N; e++) m[e] = m_issued[e];
    return m;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_idx = 0; m_wv = 0; m_wi = 0;
    for (int e = 0; e < N; e++) begin m_issued[e] = 0; fired_since[e] = 0; end
  endtask

  task automatic compare_all();
    check("issue_valid", 32'(issue_valid), 32'(m_valid));
    if (m_valid) check("issue_index", 32'(issue_index), 32'(m_idx));
    check("wakeup_valid", 32'(wakeup_valid), 32'(m_wv));
    if (m_wv) check("wakeup_index", 32'(wakeup_index), 32'(m_wi));
    check("issued_mask", 32'(issued_mask), 32'(model_mask()));
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic step(input logic [N-1:0] rdy, input int hd, input bit ir,
                      input bit av, input int ai, input bit fl);
    bit fire, found, p_valid, p_ir, p_fl;
    int pick, p_idx, e;
    ready_positions = rdy;
    head_index      = NW'(hd);
    issue_ready     = ir;
    alloc_valid     = av;
    alloc_index     = NW'(ai);
    flush           = fl;
    #1;
    if (issue_valid && issue_ready) begin
      check("issue_once", 32'(fired_since[issue_index]), 32'd0);
      fired_since[issue_index] = 1;
    end
    if (av) fired_since[ai] = 0;
    if (fl) for (int k = 0; k < N; k++) fired_since[k] = 0;

    fire  = m_valid && ir;
    found = 0;
    pick  = 0;
    for (int k = 0; k < N && !found; k++) begin
      e = (hd + k) % N;
      if (rdy[e] && !m_issued[e] && !(m_valid && e == m_idx) && !(av && e == ai)) begin
        found = 1;
        pick  = e;
      end
    end
    p_valid = m_valid; p_idx = m_idx; p_ir = ir; p_fl = fl;

    if (fl) begin
      for (int k = 0; k < N; k++) m_issued[k] = 0;
      m_valid = 0;
      m_wv    = 0;
    end else begin
      if (fire) m_issued[m_idx] = 1;
      if (av) m_issued[ai] = 0;
      m_wv = fire;
      if (fire) m_wi = m_idx;
      if (!m_valid) begin
        if (found) begin m_valid = 1; m_idx = pick; end
      end else if (fire) begin
        if (found) m_idx = pick;
        else m_valid = 0;
      end
    end

    @(posedge clk);
    #1;
    compare_all();
    if (p_valid && !p_ir && !p_fl) begin
      check("hold_valid", 32'(issue_valid), 32'd1);
      check("hold_index", 32'(issue_index), 32'(p_idx));
    end
  endtask

  initial begin
    int hd, ai;
    bit av;
    logic [N-1:0] rdy;

    rst = 1'b1; ready_positions = '0; head_index = '0; alloc_valid = 1'b0;
    alloc_index = '0; flush = 1'b0; issue_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_issue_index", 32'(issue_index), 32'd0);
    check("rst_wakeup_valid", 32'(wakeup_valid), 32'd0);
    check("rst_wakeup_index", 32'(wakeup_index), 32'd0);
    check("rst_issued_mask", 32'(issued_mask), 32'd0);

    // Nothing ready: stays idle, no wakeups.
    repeat (5) begin
      step(16'h0000, 0, 1, 0, 0, 0);
      check("idle_valid", 32'(issue_valid), 32'd0);
      check("idle_wakeup", 32'(wakeup_valid), 32'd0);
    end

    // Age order from head 4: 4, 7, 0 back to back.
    step(16'h0091, 4, 1, 0, 0, 0);
    check("ord_idx0", 32'(issue_index), 32'd4);
    step(16'h0091, 4, 1, 0, 0, 0);
    check("ord_idx1", 32'(issue_index), 32'd7);
    check("ord_wk0", 32'(wakeup_index), 32'd4);
    step(16'h0091, 4, 1, 0, 0, 0);
    check("ord_idx2", 32'(issue_index), 32'd0);
    check("ord_wk1", 32'(wakeup_index), 32'd7);
    step(16'h0091, 4, 1, 0, 0, 0);
    check("ord_done", 32'(issue_valid), 32'd0);
    check("ord_wk2", 32'(wakeup_index), 32'd0);
    check("ord_mask", 32'(issued_mask), 32'h0091);
    step(16'h0000, 0, 0, 0, 0, 1);

    // Backpressure: offer of 5 held for four cycles, one wakeup.
    step(16'h0020, 0, 0, 0, 0, 0);
    check("bp_valid0", 32'(issue_valid), 32'd1);
    check("bp_idx0", 32'(issue_index), 32'd5);
    repeat (3) begin
      step(16'h0020, 0, 0, 0, 0, 0);
      check("bp_idx", 32'(issue_index), 32'd5);
      check("bp_nowk", 32'(wakeup_valid), 32'd0);
    end
    step(16'h0020, 0, 1, 0, 0, 0);
    check("bp_wk", 32'(wakeup_valid), 32'd1);
    check("bp_wkidx", 32'(wakeup_index), 32'd5);
    check("bp_drop", 32'(issue_valid), 32'd0);
    step(16'h0020, 0, 1, 0, 0, 0);
    check("bp_single_wk", 32'(wakeup_valid), 32'd0);
    step(16'h0000, 0, 0, 0, 0, 1);

    // Wrap: head 15 then entry 1.
    step(16'h8002, 15, 1, 0, 0, 0);
    check("wrap_idx0", 32'(issue_index), 32'd15);
    step(16'h8002, 15, 1, 0, 0, 0);
    check("wrap_idx1", 32'(issue_index), 32'd1);
    step(16'h8002, 15, 1, 0, 0, 0);
    check("wrap_wk", 32'(wakeup_index), 32'd1);
    step(16'h0000, 0, 0, 0, 0, 1);

    // Fire and alloc on entry 3 together: issued bit stays clear.
    step(16'h0018, 3, 1, 0, 0, 0);
    check("fa_idx", 32'(issue_index), 32'd3);
    step(16'h0018, 3, 1, 1, 3, 0);
    check("fa_clear", 32'(issued_mask[3]), 32'd0);
    check("fa_wk", 32'(wakeup_index), 32'd3);
    check("fa_next", 32'(issue_index), 32'd4);
    // Flush during a firing offer: squashed, no wakeup.
    step(16'h0018, 3, 1, 0, 0, 1);
    check("fl_valid", 32'(issue_valid), 32'd0);
    check("fl_mask", 32'(issued_mask), 32'd0);
    check("fl_wk", 32'(wakeup_valid), 32'd0);
    step(16'h0000, 0, 0, 0, 0, 0);
    check("fl_wk_after", 32'(wakeup_valid), 32'd0);

    // Randomized run against the model.
    for (int c = 0; c < 10000; c++) begin
      rdy = N'($urandom & $urandom);
      hd  = $urandom_range(0, N - 1);
      av  = ($urandom_range(0, 1) == 1);
      ai  = $urandom_range(0, N - 1);
      issue_ready = ($urandom_range(0, 3) != 0);
      if (av && m_valid && !issue_ready && ai == m_idx) ai = (ai + 1) % N;
      step(rdy, hd, issue_ready, av, ai, ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
